// File: rtl/mycpu_ex_stage.sv
// Registered execute stage: single-cycle ALU, iterative shift-add multiplier and
// restoring divider sharing one handshaked output register.
module mycpu_ex_stage #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SHAMT_W = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [3:0]        in_op,
    input  logic [1:0]        in_mode,
    input  logic              in_signed,
    input  logic              in_ovf_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [DATA_W-1:0] out_hi,
    output logic              out_hilo_we,
    output logic              out_overflow,
    output logic              out_div0,
    output logic              out_zero
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    typedef enum logic [0:0] {StIdle, StIter} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div0_q, div0_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic [DATA_W-1:0]  hi_q, hi_d;
    logic [DATA_W-1:0]  lo_q, lo_d;

    logic               ov_q, ov_d;
    logic [DATA_W-1:0]  res_q, res_d;
    logic [DATA_W-1:0]  rhi_q, rhi_d;
    logic               hilo_q, hilo_d;
    logic               ovf_q, ovf_d;
    logic               dz_q, dz_d;
    logic               zero_q, zero_d;

    logic accept;

    assign in_ready = ~reset & ~flush & (state_q == StIdle) & (~ov_q | out_ready);
    assign accept   = in_valid & in_ready;

    // ALU
    logic [3:0]         op_eff;
    logic [DATA_W-1:0]  sum, diff, alu_res;
    logic [SHAMT_W-1:0] shamt;
    logic               alu_ovf;

    assign op_eff = (in_mode == 2'd3) ? 4'd0 : in_op;
    assign sum    = in_a + in_b;
    assign diff   = in_a - in_b;
    assign shamt  = in_b[SHAMT_W-1:0];

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op_eff)
            4'd0: begin
                alu_res = sum;
                alu_ovf = (in_a[DATA_W-1] == in_b[DATA_W-1]) && (sum[DATA_W-1] != in_a[DATA_W-1]);
            end
            4'd1: begin
                alu_res = diff;
                alu_ovf = (in_a[DATA_W-1] != in_b[DATA_W-1]) && (diff[DATA_W-1] != in_a[DATA_W-1]);
            end
            4'd2:    alu_res = in_a & in_b;
            4'd3:    alu_res = in_a | in_b;
            4'd4:    alu_res = in_a ^ in_b;
            4'd5:    alu_res = ~(in_a | in_b);
            4'd6:    alu_res = {{(DATA_W-1){1'b0}}, $signed(in_a) < $signed(in_b)};
            4'd7:    alu_res = {{(DATA_W-1){1'b0}}, in_a < in_b};
            4'd8:    alu_res = in_a << shamt;
            4'd9:    alu_res = in_a >> shamt;
            4'd10:   alu_res = $unsigned($signed(in_a) >>> shamt);
            4'd11:   alu_res = in_b << (DATA_W / 2);
            default: alu_res = '0;
        endcase
        alu_ovf = alu_ovf & in_ovf_en;
    end

    // Operand magnitudes for the iterative units
    logic              a_neg, b_neg;
    logic [DATA_W-1:0] a_mag, b_mag;

    assign a_neg = in_signed & in_a[DATA_W-1];
    assign b_neg = in_signed & in_b[DATA_W-1];
    assign a_mag = a_neg ? -in_a : in_a;
    assign b_mag = b_neg ? -in_b : in_b;

    // One iteration: MUL keeps {hi,lo} as partial product / shifting multiplier,
    // DIV keeps hi as partial remainder and lo as dividend shifting into quotient.
    logic [DATA_W:0]   mul_sum, div_shift, div_diff;
    logic [DATA_W-1:0] it_hi, it_lo;

    assign mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : '0)};
    assign div_shift = {hi_q, lo_q[DATA_W-1]};
    assign div_diff  = div_shift - {1'b0, b_q};

    always_comb begin
        if (is_div_q) begin
            if (!div_diff[DATA_W]) begin
                it_hi = div_diff[DATA_W-1:0];
                it_lo = {lo_q[DATA_W-2:0], 1'b1};
            end else begin
                it_hi = div_shift[DATA_W-1:0];
                it_lo = {lo_q[DATA_W-2:0], 1'b0};
            end
        end else begin
            it_hi = mul_sum[DATA_W:1];
            it_lo = {mul_sum[0], lo_q[DATA_W-1:1]};
        end
    end

    // Sign correction and divide-by-zero override on the final iteration
    logic [2*DATA_W-1:0] prod_mag, prod_fin;
    logic [DATA_W-1:0]   quo_fin, rem_fin, fin_lo, fin_hi;

    assign prod_mag = {it_hi, it_lo};
    assign prod_fin = neg_q ? -prod_mag : prod_mag;
    assign quo_fin  = div0_q ? '1 : (neg_q ? -it_lo : it_lo);
    assign rem_fin  = div0_q ? a_q : (neg_rem_q ? -it_hi : it_hi);
    assign fin_lo   = is_div_q ? quo_fin : prod_fin[DATA_W-1:0];
    assign fin_hi   = is_div_q ? rem_fin : prod_fin[2*DATA_W-1:DATA_W];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        a_d       = a_q;
        b_d       = b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        ov_d      = ov_q & ~out_ready;
        res_d     = res_q;
        rhi_d     = rhi_q;
        hilo_d    = hilo_q;
        ovf_d     = ovf_q;
        dz_d      = dz_q;
        zero_d    = zero_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (in_mode == 2'd1 || in_mode == 2'd2) begin
                        state_d   = StIter;
                        cnt_d     = CNT_W'(DATA_W - 1);
                        is_div_d  = (in_mode == 2'd2);
                        neg_d     = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        div0_d    = (in_mode == 2'd2) && (in_b == '0);
                        a_d       = in_a;
                        b_d       = (in_mode == 2'd2) ? b_mag : a_mag;
                        lo_d      = (in_mode == 2'd2) ? a_mag : b_mag;
                        hi_d      = '0;
                    end else begin
                        ov_d   = 1'b1;
                        res_d  = alu_res;
                        rhi_d  = '0;
                        hilo_d = 1'b0;
                        ovf_d  = alu_ovf;
                        dz_d   = 1'b0;
                        zero_d = (alu_res == '0);
                    end
                end
            end
            StIter: begin
                hi_d = it_hi;
                lo_d = it_lo;
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    ov_d    = 1'b1;
                    res_d   = fin_lo;
                    rhi_d   = fin_hi;
                    hilo_d  = 1'b1;
                    ovf_d   = 1'b0;
                    dz_d    = is_div_q & div0_q;
                    zero_d  = (fin_lo == '0);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            ov_q      <= 1'b0;
            res_q     <= '0;
            rhi_q     <= '0;
            hilo_q    <= 1'b0;
            ovf_q     <= 1'b0;
            dz_q      <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            a_q       <= a_d;
            b_q       <= b_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            ov_q      <= ov_d;
            res_q     <= res_d;
            rhi_q     <= rhi_d;
            hilo_q    <= hilo_d;
            ovf_q     <= ovf_d;
            dz_q      <= dz_d;
            zero_q    <= zero_d;
        end
    end

    assign out_valid    = ov_q;
    assign out_result   = res_q;
    assign out_hi       = rhi_q;
    assign out_hilo_we  = hilo_q;
    assign out_overflow = ovf_q;
    assign out_div0     = dz_q;
    assign out_zero     = zero_q;

endmodule
